// File: rtl/neo_rng_pkg.sv
// Shared types, default parameters and pair decoding for the multi-ring RNG.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package neo_rng_pkg;

  localparam int NUM_RO_DEF      = 5;
  localparam int DATA_W_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int SAMPLE_DIV_DEF  = 4;
  localparam int WARMUP_CYC_DEF  = 16;
  localparam int DEBIAS_DEF      = 1;
  localparam int REP_LIMIT_DEF   = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP  = 2'd1,
    COLLECT = 2'd2
  } state_t;

  typedef struct packed {
    logic vld;
    logic dat;
  } pair_t;

  // Von Neumann pair: 01 -> 0, 10 -> 1, equal bits carry no entropy.
  function automatic pair_t pair_decode(input logic first, input logic second);
    pair_t p;
    p.vld = first ^ second;
    p.dat = first;
    return p;
  endfunction

endpackage

// File: rtl/ring_oscillator_cell.sv
// Entropy cell: one gated inverter loop closed around a sampling node.
// Latency: node toggles every clk while enabled.
// Backpressure: none; parks at INIT whenever the gate is low.
module ring_oscillator_cell #(
  parameter logic INIT = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_ro
);

  logic r_node;
  logic w_inv;

  // Odd-length inverter ring collapses to a single net inversion of the node.
  assign w_inv = ~r_node;

  // Loop runs while gated on; gated off it rests at a fixed level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_node <= INIT;
    end else if (i_en) begin
      r_node <= w_inv;
    end else begin
      r_node <= INIT;
    end
  end

  assign o_ro = r_node;

endmodule

// File: rtl/neo_rng_multi.sv
// Multi-ring TRNG: XOR of synchronised rings -> debias -> health test -> DATA_W-bit words.
// Latency: (WARMUP_CYC + 2*DATA_W)*SAMPLE_DIV + 1 cycles from enable to first word (ideal pairs).
// Backpressure: one word held on data_o plus one full accumulator; further bits dropped.
module neo_rng_multi
  import neo_rng_pkg::*;
#(
  parameter int NUM_RO      = NUM_RO_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int SAMPLE_DIV  = SAMPLE_DIV_DEF,
  parameter int WARMUP_CYC  = WARMUP_CYC_DEF,
  parameter int DEBIAS      = DEBIAS_DEF,
  parameter int REP_LIMIT   = REP_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  input  logic              test_mode_i,
  input  logic [NUM_RO-1:0] test_bits_i,
  input  logic              load,
  input  logic [DATA_W-1:0] seed_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int WRM_W = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int REP_W = $clog2(REP_LIMIT + 1);

  state_t            r_state, w_state_nxt;
  logic [DIV_W-1:0]  r_div;
  logic [WRM_W-1:0]  r_warm;
  logic [NUM_RO-1:0] w_ro, w_src;
  logic [NUM_RO-1:0] r_sync [SYNC_STAGES];
  logic              w_ro_en, w_go_idle, w_tick, w_ctick, w_raw, w_load;
  logic              r_phase, r_first;
  pair_t             w_pair;
  logic              w_acc_vld, w_acc_bit;
  logic              r_last, r_err;
  logic [REP_W-1:0]  r_rep, w_rep_nxt;
  logic [DATA_W-1:0] r_acc, r_data;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_full, w_move, w_take, r_valid;

  // Rings only run when they are the live entropy source.
  assign w_ro_en = enable_i & ~test_mode_i;

  for (genvar g = 0; g < NUM_RO; g++) begin : g_ro
    ring_oscillator_cell #(.INIT(1'(g % 2))) u_ro (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_en    (w_ro_en),
      .o_ro    (w_ro[g])
    );
  end

  assign w_src = test_mode_i ? test_bits_i : w_ro;

  // Metastability chain; test bits enter at the same point as ring outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= w_src;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_raw     = ^r_sync[SYNC_STAGES-1];
  assign w_go_idle = ~enable_i;
  assign w_tick    = (r_state != IDLE) && (r_div == DIV_W'(SAMPLE_DIV - 1));
  assign w_ctick   = w_tick && (r_state == COLLECT);
  assign w_load    = load && (r_state == COLLECT);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state; dropping enable wins from any state.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (enable_i) w_state_nxt = WARMUP;
      WARMUP:  if (w_tick && r_warm == WRM_W'(WARMUP_CYC - 1)) w_state_nxt = COLLECT;
      COLLECT: w_state_nxt = COLLECT;
      default: w_state_nxt = IDLE;
    endcase
    if (w_go_idle) w_state_nxt = IDLE;
  end

  // Sample divider and warm-up tick count; both idle at zero outside their states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div  <= '0;
      r_warm <= '0;
    end else begin
      if (w_go_idle || r_state == IDLE) r_div <= '0;
      else if (w_tick)                  r_div <= '0;
      else                              r_div <= r_div + DIV_W'(1);
      if (r_state != WARMUP) r_warm <= '0;
      else if (w_tick)       r_warm <= r_warm + WRM_W'(1);
    end
  end

  // Pair tracking: phase 0 stores the first bit, phase 1 decodes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase <= 1'b0;
      r_first <= 1'b0;
    end else if (w_go_idle || w_load) begin
      r_phase <= 1'b0;
    end else if (w_ctick) begin
      r_phase <= ~r_phase;
      if (!r_phase) r_first <= w_raw;
    end
  end

  assign w_pair = pair_decode(r_first, w_raw);

  // Accepted-bit selection; a tripped health test stops word production.
  always_comb begin
    w_acc_vld = 1'b0;
    w_acc_bit = w_raw;
    if (w_ctick && !r_err) begin
      if (DEBIAS == 0) begin
        w_acc_vld = 1'b1;
      end else if (r_phase) begin
        w_acc_vld = w_pair.vld;
        w_acc_bit = w_pair.dat;
      end
    end
  end

  // Run length of identical raw bits, saturating at the limit.
  always_comb begin
    w_rep_nxt = REP_W'(1);
    if (r_rep != '0 && w_raw == r_last) begin
      w_rep_nxt = (r_rep == REP_W'(REP_LIMIT)) ? r_rep : r_rep + REP_W'(1);
    end
  end

  // Repetition-count health test with sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rep  <= '0;
      r_last <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_go_idle) begin
      r_rep  <= '0;
      r_last <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_ctick) begin
      r_rep  <= w_rep_nxt;
      r_last <= w_raw;
      if (w_rep_nxt == REP_W'(REP_LIMIT)) r_err <= 1'b1;
    end
  end

  assign w_full = (r_cnt == CNT_W'(DATA_W));
  assign w_move = w_full && (!r_valid || ready_i) && !r_err;
  assign w_take = w_acc_vld && !w_full;

  // Accumulator: seed load beats a word hand-off, which beats a plain shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_go_idle) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_acc <= seed_i;
      r_cnt <= '0;
    end else if (w_move) begin
      r_acc <= {r_acc[DATA_W-2:0], w_acc_bit};
      r_cnt <= w_acc_vld ? CNT_W'(1) : '0;
    end else if (w_take) begin
      r_acc <= {r_acc[DATA_W-2:0], w_acc_bit};
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Output word register; data_o keeps its last word across idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_go_idle) begin
      r_valid <= 1'b0;
    end else if (w_move) begin
      r_valid <= 1'b1;
      r_data  <= r_acc;
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign busy_o  = (r_state != IDLE);
  assign err_o   = r_err;

endmodule

// File: tb/tb_neo_rng_multi.sv
// Directed bench for neo_rng_multi in test-bit mode with word scoreboards.
// Latency: test bit for collect tick j is driven two cycles after the tick counter starts.
// Backpressure: ready_i driven by the bench; transfers popped on valid & ready.
module tb_neo_rng_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable_i = 1'b0;
  logic       test_mode_i = 1'b1;
  logic [0:0] test_bits_i = 1'b0;
  logic       load = 1'b0;
  logic [7:0] seed_i = 8'h00;
  logic       ready_i = 1'b1;

  logic       d_valid, d_busy, d_err;
  logic [7:0] d_data;
  logic       r_valid, r_busy, r_err;
  logic [7:0] r_data;

  int         checks = 0;
  int         errors = 0;
  int         vld_cnt = 0;
  int         tb_j = 0;
  bit         raw_on = 1'b0;
  logic       pat[$];
  logic [7:0] q_dut[$];
  logic [7:0] q_raw[$];

  neo_rng_multi #(.NUM_RO(1), .DATA_W(8), .SYNC_STAGES(2), .SAMPLE_DIV(1),
                  .WARMUP_CYC(4), .DEBIAS(1), .REP_LIMIT(32)) u_dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .test_mode_i(test_mode_i),
    .test_bits_i(test_bits_i), .load(load), .seed_i(seed_i), .ready_i(ready_i),
    .valid_o(d_valid), .data_o(d_data), .busy_o(d_busy), .err_o(d_err)
  );

  neo_rng_multi #(.NUM_RO(1), .DATA_W(8), .SYNC_STAGES(2), .SAMPLE_DIV(1),
                  .WARMUP_CYC(4), .DEBIAS(0), .REP_LIMIT(32)) u_raw (
    .clk(clk), .rst(rst), .enable_i(enable_i), .test_mode_i(test_mode_i),
    .test_bits_i(test_bits_i), .load(load), .seed_i(seed_i), .ready_i(ready_i),
    .valid_o(r_valid), .data_o(r_data), .busy_o(r_busy), .err_o(r_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic pat_at(input int j);
    if (j < 0 || j >= pat.size()) return 1'b0;
    return pat[j];
  endfunction

  task automatic start_run();
    @(posedge clk); #1;
    enable_i    = 1'b1;
    test_bits_i = pat_at(-3);
    tb_j        = -2;
    vld_cnt     = 0;
  endtask

  // After step(n) following start_run, the bench sits in cycle n-1 after the enable edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      test_bits_i = pat_at(tb_j);
      tb_j++;
    end
  endtask

  task automatic stop_run();
    @(posedge clk); #1;
    enable_i = 1'b0;
    load     = 1'b0;
    @(posedge clk); #1;
  endtask

  // Scoreboard for the debiasing instance: every transfer must be expected.
  always @(negedge clk) begin
    if (rst && d_valid && ready_i) begin
      check("dut_word_expected", 32'(q_dut.size() > 0), 32'd1);
      if (q_dut.size() > 0) check("dut_word", 32'(d_data), 32'(q_dut.pop_front()));
    end
    if (rst && d_valid) vld_cnt++;
  end

  // Scoreboard for the raw instance, armed only for the seed-load step.
  always @(negedge clk) begin
    if (rst && raw_on && r_valid && ready_i) begin
      check("raw_word_expected", 32'(q_raw.size() > 0), 32'd1);
      if (q_raw.size() > 0) check("raw_word", 32'(r_data), 32'(q_raw.pop_front()));
    end
  end

  initial begin
    // Reset values
    #1 rst = 1'b0;
    #1;
    check("rst_valid", 32'(d_valid), 32'd0);
    check("rst_data",  32'(d_data),  32'd0);
    check("rst_busy",  32'(d_busy),  32'd0);
    check("rst_err",   32'(d_err),   32'd0);
    check("rst_raw_valid", 32'(r_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Debias ones: alternating 1,0 -> pairs 10 -> 0xFF every 16 collect ticks
    pat.delete();
    for (int i = 0; i < 48; i++) pat.push_back(i % 2 == 0);
    repeat (3) q_dut.push_back(8'hFF);
    ready_i = 1'b1;
    start_run();
    step(1);
    check("busy_on", 32'(d_busy), 32'd1);
    step(20);
    check("lat_early", 32'(d_valid), 32'd0);
    step(1);
    check("lat_first", 32'(d_valid), 32'd1);
    step(34);
    check("ones_vld_pulses", 32'(vld_cnt), 32'd3);
    check("ones_q_empty", 32'(q_dut.size()), 32'd0);
    stop_run();
    check("ones_busy_off", 32'(d_busy), 32'd0);
    check("ones_valid_off", 32'(d_valid), 32'd0);
    check("ones_data_kept", 32'(d_data), 32'hFF);

    // Debias zeros and discard: 0,1,1,1 -> pairs 01 (0) and 11 (dropped)
    pat.delete();
    for (int i = 0; i < 64; i++) pat.push_back(i % 4 != 0);
    repeat (2) q_dut.push_back(8'h00);
    start_run();
    step(72);
    check("zeros_vld_pulses", 32'(vld_cnt), 32'd2);
    check("zeros_q_empty", 32'(q_dut.size()), 32'd0);
    check("zeros_err", 32'(d_err), 32'd0);
    stop_run();

    // Backpressure: 0xFF held, 0x00 fills behind it, extra ones dropped
    pat.delete();
    for (int i = 0; i < 48; i++) pat.push_back((i < 16 || i >= 32) ? (i % 2 == 0) : (i % 2 == 1));
    q_dut.push_back(8'hFF);
    q_dut.push_back(8'h00);
    ready_i = 1'b0;
    start_run();
    step(31);
    check("bp_hold_valid", 32'(d_valid), 32'd1);
    check("bp_hold_data",  32'(d_data),  32'hFF);
    step(23);
    check("bp_stall_valid", 32'(d_valid), 32'd1);
    check("bp_stall_data",  32'(d_data),  32'hFF);
    ready_i = 1'b1;
    step(1);
    check("bp_b2b_valid", 32'(d_valid), 32'd1);
    step(1);
    check("bp_drain_valid", 32'(d_valid), 32'd0);
    check("bp_q_empty", 32'(q_dut.size()), 32'd0);
    stop_run();

    // Seed load on the raw instance: 0xA5 replaced by raw 1,1,1,1,0,0,0,0
    pat.delete();
    for (int i = 0; i < 11; i++) pat.push_back(i >= 3 && i <= 6);
    q_raw.push_back(8'hF0);
    seed_i = 8'hA5;
    raw_on = 1'b1;
    start_run();
    step(7);
    load = 1'b1;
    step(1);
    load = 1'b0;
    step(13);
    check("seed_q_empty", 32'(q_raw.size()), 32'd0);
    check("seed_data", 32'(r_data), 32'hF0);
    stop_run();
    raw_on = 1'b0;

    // Health test: 32 raw zeros trip err_o; later good pairs yield no word
    pat.delete();
    for (int i = 0; i < 72; i++) pat.push_back(i >= 32 && (i % 2 == 0));
    start_run();
    step(36);
    check("health_pre", 32'(d_err), 32'd0);
    step(1);
    check("health_trip", 32'(d_err), 32'd1);
    step(45);
    check("health_sticky", 32'(d_err), 32'd1);
    check("health_no_words", 32'(vld_cnt), 32'd0);
    stop_run();
    check("health_err_clear", 32'(d_err), 32'd0);
    check("health_busy_off", 32'(d_busy), 32'd0);

    // Asynchronous reset mid-run while a word is pending
    pat.delete();
    for (int i = 0; i < 48; i++) pat.push_back(i % 2 == 0);
    ready_i = 1'b0;
    start_run();
    step(26);
    check("arst_pre_valid", 32'(d_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 32'(d_valid), 32'd0);
    check("arst_data",  32'(d_data),  32'd0);
    check("arst_busy",  32'(d_busy),  32'd0);
    check("arst_err",   32'(d_err),   32'd0);
    enable_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
